// File: rtl/uram_like_bram2_pkg.sv
// Shared constants and helpers for the uram_like_bram2 memory model.
// Optional parity storage is enabled by defining URAM_LIKE_PARITY_EN.
package uram_like_pkg;

    localparam int WRITE_MODE_READ_FIRST  = 0;
    localparam int WRITE_MODE_WRITE_FIRST = 1;
    localparam int MAX_READ_LATENCY       = 8;

    // byte_merge works on a fixed maximum width; callers zero-extend and truncate.
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    // New bytes where be is set, old bytes elsewhere.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_w,
        input logic [MAX_DATA_WIDTH-1:0] new_w,
        input logic [MAX_BYTES-1:0]      be
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uram_like_bram2_if.sv
// Bus interface for uram_like_bram2: one write port, one read port.
// perr / perr_inject exist only when URAM_LIKE_PARITY_EN is defined.
interface uram_like_bram2_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12
);
    logic                       ren;
    logic [ADDRESS_WIDTH-1:0]   raddr;
    logic                       hold;
    logic [DATA_WIDTH-1:0]      dout;
    logic                       rvalid;
    logic [DATA_WIDTH/8-1:0]    wen;
    logic [ADDRESS_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]      din;
`ifdef URAM_LIKE_PARITY_EN
    logic                       perr;
    logic                       perr_inject;

    modport master (
        output ren, raddr, hold, wen, waddr, din, perr_inject,
        input  dout, rvalid, perr
    );
    modport slave (
        input  ren, raddr, hold, wen, waddr, din, perr_inject,
        output dout, rvalid, perr
    );
`else
    modport master (
        output ren, raddr, hold, wen, waddr, din,
        input  dout, rvalid
    );
    modport slave (
        input  ren, raddr, hold, wen, waddr, din,
        output dout, rvalid
    );
`endif
endinterface

// File: rtl/uram_like_bram2_rd_pipe.sv
// Read pipeline: DEPTH-stage data+valid shift register with a global hold.
// Stage 0 captures the incoming word; the last stage drives the outputs.
module uram_like_rd_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             hold_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    // Shift all stages together unless held; reset drops every in-flight read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (!hold_i) begin
            data_q[0] <= data_i;
            vld_q[0]  <= vld_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    assign data_o = data_q[DEPTH-1];
    assign vld_o  = vld_q[DEPTH-1];

endmodule

// File: rtl/uram_like_bram2.sv
// Simple-dual-port behavioural memory: byte write enables, selectable
// read-first / write-first collision policy, held read pipeline.
// Define URAM_LIKE_PARITY_EN to add per-byte even parity with perr output.
module uram_like_bram2
    import uram_like_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_MODE    = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    uram_like_bram2_if.slave bus
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
`ifdef URAM_LIKE_PARITY_EN
    localparam int PW = DATA_WIDTH + 1;
`else
    localparam int PW = DATA_WIDTH;
`endif

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $fatal(1, "uram_like_bram2: DATA_WIDTH must be a multiple of 8 and <= MAX_DATA_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $fatal(1, "uram_like_bram2: READ_LATENCY must be in 1..8");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word_d;
    logic                  collide;
    logic [PW-1:0]         pipe_d;
    logic [PW-1:0]         pipe_q;
    logic                  vld_q;

    assign old_word    = mem_q[bus.raddr];
    assign collide     = (bus.wen != '0) && (bus.raddr == bus.waddr);
    assign merged_word = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word),
                                                MAX_DATA_WIDTH'(bus.din),
                                                MAX_BYTES'(bus.wen)));

`ifdef URAM_LIKE_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wpar;
    logic [NB-1:0] rd_par_d;
    logic          perr_d;

    // Even parity bit per byte, so byte plus parity has an even number of ones.
    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

    assign wpar = byte_par(bus.din) ^ {NB{bus.perr_inject}};
`endif

    // Array write: per-byte update, independent of hold, ignored while in reset.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wen[i]) begin
                    mem_q[bus.waddr][8*i +: 8] <= bus.din[8*i +: 8];
`ifdef URAM_LIKE_PARITY_EN
                    par_q[bus.waddr][i] <= wpar[i];
`endif
                end
            end
        end
    end

    // Collision mux: write-first forwards merged bytes into the read word.
    always_comb begin
        rd_word_d = old_word;
`ifdef URAM_LIKE_PARITY_EN
        rd_par_d = par_q[bus.raddr];
`endif
        if (WRITE_MODE == WRITE_MODE_WRITE_FIRST && collide) begin
            rd_word_d = merged_word;
`ifdef URAM_LIKE_PARITY_EN
            rd_par_d = (par_q[bus.raddr] & ~bus.wen) | (wpar & bus.wen);
`endif
        end
`ifdef URAM_LIKE_PARITY_EN
        perr_d = |(byte_par(rd_word_d) ^ rd_par_d);
        pipe_d = bus.ren ? {perr_d, rd_word_d} : '0;
`else
        pipe_d = bus.ren ? rd_word_d : '0;
`endif
    end

    uram_like_rd_pipe #(
        .WIDTH (PW),
        .DEPTH (READ_LATENCY)
    ) u_rd_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .hold_i  (bus.hold),
        .vld_i   (bus.ren),
        .data_i  (pipe_d),
        .vld_o   (vld_q),
        .data_o  (pipe_q)
    );

    assign bus.rvalid = vld_q;
    assign bus.dout   = pipe_q[DATA_WIDTH-1:0];
`ifdef URAM_LIKE_PARITY_EN
    assign bus.perr   = pipe_q[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_uram_like_bram2.sv
// Directed bench for uram_like_bram2: two instances (read-first and
// write-first), READ_LATENCY=2. Parity steps run when URAM_LIKE_PARITY_EN is defined.
module tb_uram_like_bram2;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    uram_like_bram2_if #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12)) if0 ();
    uram_like_bram2_if #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12)) if1 ();

    uram_like_bram2 #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12), .READ_LATENCY(2), .WRITE_MODE(0))
        u_rf (.clock(clk), .reset_n(reset_n), .bus(if0));
    uram_like_bram2 #(.DATA_WIDTH(64), .ADDRESS_WIDTH(12), .READ_LATENCY(2), .WRITE_MODE(1))
        u_wf (.clock(clk), .reset_n(reset_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        if0.ren = 1'b1; if0.raddr = '0; if0.hold = 1'b0;
        if0.wen = '0;   if0.waddr = '0; if0.din  = '0;
        if1.ren = 1'b0; if1.raddr = '0; if1.hold = 1'b0;
        if1.wen = '0;   if1.waddr = '0; if1.din  = '0;
`ifdef URAM_LIKE_PARITY_EN
        if0.perr_inject = 1'b0;
        if1.perr_inject = 1'b0;
`endif
        #1;

        // Reset held 3 cycles with ren=1: outputs stay zero
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rvalid", 64'(if0.rvalid), 64'd0);
            check("rst_dout", if0.dout, 64'd0);
        end
        reset_n = 1'b1;
        tick();
        check("first_rd_lat1_rvalid", 64'(if0.rvalid), 64'd0);
        tick();
        check("first_rd_lat2_rvalid", 64'(if0.rvalid), 64'd1);
        if0.ren = 1'b0;

        // Full-word write then read
        if0.wen = 8'hFF; if0.waddr = 12'h005; if0.din = 64'h1122334455667788;
        tick();
        if0.wen = '0;
        if0.ren = 1'b1; if0.raddr = 12'h005;
        tick();
        if0.ren = 1'b0;
        check("basic_lat1_rvalid", 64'(if0.rvalid), 64'd0);
        tick();
        check("basic_rvalid", 64'(if0.rvalid), 64'd1);
        check("basic_dout", if0.dout, 64'h1122334455667788);

        // Byte-enable partial write
        if0.wen = 8'h0F; if0.waddr = 12'h005; if0.din = 64'hAAAAAAAAAAAAAAAA;
        tick();
        if0.wen = '0;
        if0.ren = 1'b1; if0.raddr = 12'h005;
        tick();
        if0.ren = 1'b0;
        tick();
        check("be_rvalid", 64'(if0.rvalid), 64'd1);
        check("be_dout", if0.dout, 64'h11223344AAAAAAAA);

        // Collision: word 0 holds 1, same-cycle write 2 and read 0
        if0.wen = 8'hFF; if0.waddr = '0; if0.din = 64'd1;
        if1.wen = 8'hFF; if1.waddr = '0; if1.din = 64'd1;
        tick();
        if0.din = 64'd2; if0.ren = 1'b1; if0.raddr = '0;
        if1.din = 64'd2; if1.ren = 1'b1; if1.raddr = '0;
        tick();
        if0.wen = '0; if0.ren = 1'b0;
        if1.wen = '0; if1.ren = 1'b0;
        tick();
        check("coll_rf_dout", if0.dout, 64'd1);
        check("coll_wf_dout", if1.dout, 64'd2);
        check("coll_wf_rvalid", 64'(if1.rvalid), 64'd1);

        // Partial-byte collision: word 0 holds 2, write byte1=0xFF
        if0.wen = 8'h02; if0.waddr = '0; if0.din = 64'h000000000000FF00; if0.ren = 1'b1; if0.raddr = '0;
        if1.wen = 8'h02; if1.waddr = '0; if1.din = 64'h000000000000FF00; if1.ren = 1'b1; if1.raddr = '0;
        tick();
        if0.wen = '0;
        if1.wen = '0;
        tick();
        if0.ren = 1'b0;
        if1.ren = 1'b0;
        check("pcoll_rf_dout", if0.dout, 64'd2);
        check("pcoll_wf_dout", if1.dout, 64'h000000000000FF02);
        tick();
        check("pcoll_rf_after", if0.dout, 64'h000000000000FF02);

        // Hold: reads of 1,2,3 with 4 held cycles after the second issue
        for (int a = 1; a <= 3; a++) begin
            if0.wen = 8'hFF; if0.waddr = 12'(a); if0.din = 64'(a);
            tick();
        end
        if0.wen = '0;
        if0.ren = 1'b1; if0.raddr = 12'h001;
        tick();
        if0.raddr = 12'h002;
        tick();
        check("hold_pre_dout", if0.dout, 64'd1);
        if0.raddr = 12'h003; if0.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_frz_rvalid", 64'(if0.rvalid), 64'd1);
            check("hold_frz_dout", if0.dout, 64'd1);
        end
        if0.hold = 1'b0;
        tick();
        if0.ren = 1'b0;
        check("hold_rel_dout2", if0.dout, 64'd2);
        check("hold_rel_rvalid2", 64'(if0.rvalid), 64'd1);
        tick();
        check("hold_rel_dout3", if0.dout, 64'd3);
        check("hold_rel_rvalid3", 64'(if0.rvalid), 64'd1);
        tick();
        check("hold_end_rvalid", 64'(if0.rvalid), 64'd0);
        check("hold_end_dout", if0.dout, 64'd0);

        // Reset with two reads in flight
        if0.ren = 1'b1; if0.raddr = 12'h001;
        tick();
        if0.raddr = 12'h002;
        tick();
        reset_n = 1'b0; if0.ren = 1'b0;
        #1;
        check("midrst_rvalid", 64'(if0.rvalid), 64'd0);
        check("midrst_dout", if0.dout, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("postrst_rvalid1", 64'(if0.rvalid), 64'd0);
        tick();
        check("postrst_rvalid2", 64'(if0.rvalid), 64'd0);

`ifdef URAM_LIKE_PARITY_EN
        // Parity: clean full word, injected byte 0, then clean rewrite of byte 0
        if0.wen = 8'hFF; if0.waddr = 12'h007; if0.din = 64'h0123456789ABCDEF;
        tick();
        if0.wen = '0; if0.ren = 1'b1; if0.raddr = 12'h007;
        tick();
        if0.ren = 1'b0;
        tick();
        check("par_clean_perr", 64'(if0.perr), 64'd0);
        if0.wen = 8'h01; if0.din = 64'h0000000000000055; if0.perr_inject = 1'b1;
        tick();
        if0.wen = '0; if0.perr_inject = 1'b0; if0.ren = 1'b1;
        tick();
        if0.ren = 1'b0;
        tick();
        check("par_inj_rvalid", 64'(if0.rvalid), 64'd1);
        check("par_inj_perr", 64'(if0.perr), 64'd1);
        check("par_inj_dout", if0.dout, 64'h0123456789ABCD55);
        if0.wen = 8'h01; if0.din = 64'h0000000000000055;
        tick();
        if0.wen = '0; if0.ren = 1'b1;
        tick();
        if0.ren = 1'b0;
        tick();
        check("par_fix_perr", 64'(if0.perr), 64'd0);
        check("par_fix_rvalid", 64'(if0.rvalid), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uram_like_bram2.md
Name: uram_like_bram2

Overview:
- Next-generation simple-dual-port memory model: one write port, one read port, single clock.
- Generalised over the existing fixed URAM-style memory:
  - byte-granular write enables
  - selectable read-first / write-first collision mode
  - read-enable with a matching valid pipeline
  - pipeline hold (clock-enable) for back-pressure
- Used as the instruction/register-file store in Manticore cores and as a Verilator-friendly behavioural stand-in for the vendor macro.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8.
- ADDRESS_WIDTH, 12, depth = 2**ADDRESS_WIDTH words.
- READ_LATENCY, 2, cycles from accepted read to dout/rvalid; legal range 1..8.
- WRITE_MODE, 0, 0 = read_first, 1 = write_first (same-cycle same-address collision policy).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset; clears pipeline state only, not array contents
- ren  in  1  read request
- raddr  in  ADDRESS_WIDTH  read address, sampled when ren=1 and hold=0
- hold  in  1  freezes the entire read pipeline, including dout and rvalid
- dout  out  DATA_WIDTH  read data
- rvalid  out  1  dout carries data for a read issued READ_LATENCY unheld cycles earlier
- wen  in  DATA_WIDTH/8  per-byte write enable; bit i covers din[8i+7:8i]
- waddr  in  ADDRESS_WIDTH  write address
- din  in  DATA_WIDTH  write data

Behaviour:
- Reset (async assert, sync release):
  - All pipeline data stages clear to 0, all valid stages clear to 0.
  - So dout=0 and rvalid=0 during and immediately after reset.
  - Memory array is not cleared; contents are undefined until written.
- Writes:
  - Each byte with wen[i]=1 updates at the clock edge.
  - hold does not affect writes.
  - Writes during reset_n=0 are ignored.
- Read acceptance: a read is accepted when ren=1 and hold=0. Stage 0 captures the array word and valid=1. With ren=0 and hold=0, stage 0 captures valid=0; its data is don't-care but driven to 0.
- Pipeline advance:
  - Stages 1..READ_LATENCY-1 shift every cycle hold=0.
  - With hold=1, every stage, dout and rvalid hold their value.
  - Latency is counted in unheld cycles only.
- Output: dout = last stage data; rvalid = last stage valid. dout is 0 whenever rvalid=0 (zeroed stage data).
- Collision (ren=1, hold=0, wen!=0, raddr==waddr):
  - WRITE_MODE=0: the read returns the old word.
  - WRITE_MODE=1: the read returns the merged word (new bytes where wen set, old bytes elsewhere).
  - Partial-byte writes merge correctly in both modes.
- Boundaries:
  - Address wrap is not applicable (full decode).
  - READ_LATENCY=1: dout is stage 0 directly.
  - Reset asserted mid-read discards all in-flight reads; no rvalid is produced for them.
  - hold asserted while ren=1: the read is not accepted and must be re-presented.
- Elaboration error (initial $fatal) if DATA_WIDTH%8!=0 or READ_LATENCY outside 1..8.

Optional Feature:
- Macro: URAM_LIKE_PARITY_EN.
- When defined:
  - Array stores one even-parity bit per byte (DATA_WIDTH/8 extra bits), computed on write per enabled byte.
  - An extra output perr (1 bit) is pipelined alongside dout. It is 1 when rvalid=1 and any read byte's parity mismatches.
  - An extra input perr_inject (1 bit) flips the stored parity of all enabled bytes in that write.
  - perr resets to 0 and holds with hold.
- When not defined: no parity storage, no perr or perr_inject ports; behaviour otherwise identical.

Decomposition:
- Package uram_like_pkg:
  - WRITE_MODE_READ_FIRST=0, WRITE_MODE_WRITE_FIRST=1 constants
  - MAX_READ_LATENCY=8
  - function byte_merge(old, new, be)
- Sub-module uram_like_rd_pipe: parametrised-depth data+valid shift register with hold and async reset, instantiated once. The top contains the array, write logic and collision mux.

Test Plan:
- Reset/idle: reset_n=0 for 3 cycles, ren=1 throughout → dout=0, rvalid=0. First rvalid appears exactly READ_LATENCY cycles after the first post-reset accepted read.
- Basic write/read, READ_LATENCY=2: write 0x1122334455667788 to 0x005 with wen=0xFF. Read 0x005 next cycle → rvalid=1 and dout=0x1122334455667788 two cycles later.
- Byte enables: over the word above, write din=0xAAAAAAAAAAAAAAAA with wen=0x0F. Read back → 0x11223344AAAAAAAA.
- Collision:
  - WRITE_MODE=0, word 0x00 holds 0x1, same-cycle write 0x2 and read 0x00 → dout=0x1.
  - Repeat with WRITE_MODE=1 → dout=0x2.
- Hold: issue reads at 0x1,0x2,0x3 back-to-back, assert hold for 4 cycles after the second issue → outputs freeze for 4 cycles. Data then arrive in order 0x1,0x2,0x3, each exactly once, with no duplicate rvalid.
- Reset mid-flight plus parity (URAM_LIKE_PARITY_EN):
  - Assert reset_n=0 with 2 reads in flight → no rvalid after release.
  - Write with perr_inject=1, wen=0x01, then read → perr=1 with rvalid=1.
  - Rewrite without inject → perr=0.
